alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 16-bit six-control-bit ALU (zx/nx/zy/ny/f/no).
- Generalises operand width and adds a 2-stage registered datapath with valid/ready handshake on input and output.
- Adds zr/ng status flags and a pass-through transaction tag.
- Sits between the decode/operand-fetch stage and writeback; throughput is one operation per cycle with full backpressure.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_precond.sv | 17 +
 rtl/alu_pipe.sv | 160 ++++++++++++++++
 tb/tb_alu_pipe.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the pipelined ALU (alu_pipe).
// Control word layout is {zx, nx, zy, ny, f, no} with zx in the MSB.
package alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam logic [5:0] ALU_ZERO = 6'b101010;
    localparam logic [5:0] ALU_ONE  = 6'b111111;
    localparam logic [5:0] ALU_NEG1 = 6'b111010;
    localparam logic [5:0] ALU_X    = 6'b001100;
    localparam logic [5:0] ALU_Y    = 6'b110000;
    localparam logic [5:0] ALU_NOTX = 6'b001101;
    localparam logic [5:0] ALU_NEGX = 6'b001111;
    localparam logic [5:0] ALU_XP1  = 6'b011111;
    localparam logic [5:0] ALU_ADD  = 6'b000010;
    localparam logic [5:0] ALU_SUB  = 6'b010011;
    localparam logic [5:0] ALU_RSUB = 6'b000111;
    localparam logic [5:0] ALU_AND  = 6'b000000;
    localparam logic [5:0] ALU_OR   = 6'b010101;

endpackage

// File: rtl/alu_precond.sv
// Operand conditioning for one ALU input: optional zeroing, then optional
// bitwise inversion of the (possibly zeroed) value.
module alu_precond #(
    parameter int WIDTH = 16
) (
    input  logic             i_zero,
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_zeroed;

    assign w_zeroed = i_zero ? '0 : i_data;
    assign o_data   = i_neg ? ~w_zeroed : w_zeroed;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, zr/ng flags and tag.
// Define ALU_PIPE_ARITH_FLAGS_EN to add the out_carry/out_ovf outputs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [5:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zr,
`ifdef ALU_PIPE_ARITH_FLAGS_EN
    output logic             out_carry,
    output logic             out_ovf,
`endif
    output logic             out_ng
);

    // Handshake: a stage transfers on a cycle where its valid and ready are
    // both 1. S1 may accept whenever it is empty or is emptying into S2 this
    // cycle, so in_ready never looks at in_valid and full throughput holds.

    alu_ctrl_t        w_ctrl;
    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_y1;
    logic             w_in_fire;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_sum_lo;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;
    logic             w_zr;
    logic             w_ng;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_y;
    logic             r_s1_f;
    logic             r_s1_no;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_zr;
    logic             r_s2_ng;

    assign w_ctrl = alu_ctrl_t'(in_ctrl);

    alu_precond #(.WIDTH(WIDTH)) u_pre_x (
        .i_zero (w_ctrl.zx),
        .i_neg  (w_ctrl.nx),
        .i_data (in_x),
        .o_data (w_x1)
    );

    alu_precond #(.WIDTH(WIDTH)) u_pre_y (
        .i_zero (w_ctrl.zy),
        .i_neg  (w_ctrl.ny),
        .i_data (in_y),
        .o_data (w_y1)
    );

    assign w_s2_adv  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_f     <= 1'b0;
            r_s1_no    <= 1'b0;
            r_s1_tag   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_x     <= w_x1;
                r_s1_y     <= w_y1;
                r_s1_f     <= w_ctrl.f;
                r_s1_no    <= w_ctrl.no;
                r_s1_tag   <= in_tag;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_PIPE_ARITH_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic           w_carry;
    logic           w_ovf;
    logic           r_s2_carry;
    logic           r_s2_ovf;

    assign w_sum    = {1'b0, r_s1_x} + {1'b0, r_s1_y};
    assign w_sum_lo = w_sum[WIDTH-1:0];
    // Flags describe the raw sum, before the output inversion; AND ops report 0.
    assign w_carry  = r_s1_f && w_sum[WIDTH];
    assign w_ovf    = r_s1_f && (r_s1_x[WIDTH-1] == r_s1_y[WIDTH-1])
                             && (w_sum[WIDTH-1] != r_s1_x[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_carry <= 1'b0;
            r_s2_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_carry <= w_carry;
            r_s2_ovf   <= w_ovf;
        end
    end

    assign out_carry = r_s2_carry;
    assign out_ovf   = r_s2_ovf;
`else
    assign w_sum_lo = r_s1_x + r_s1_y;
`endif

    assign w_r   = r_s1_f ? w_sum_lo : (r_s1_x & r_s1_y);
    assign w_res = r_s1_no ? ~w_r : w_r;
    assign w_zr  = (w_res == '0);
    assign w_ng  = w_res[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_zr    <= 1'b0;
            r_s2_ng    <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= w_res;
                r_s2_tag   <= r_s1_tag;
                r_s2_zr    <= w_zr;
                r_s2_ng    <= w_ng;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign out_zr    = r_s2_zr;
    assign out_ng    = r_s2_ng;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized
// stream scored against a behavioural model through an expected queue.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int EW = 22; // {carry, ovf, tag[3:0], data[15:0]}

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [5:0]  in_ctrl;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_zr;
    logic        out_ng;
`ifdef ALU_PIPE_ARITH_FLAGS_EN
    logic        out_carry;
    logic        out_ovf;
    logic        n_out_carry;
    logic        n_out_ovf;
`endif

    logic        n_in_valid;
    logic        n_in_ready;
    logic [7:0]  n_in_x;
    logic [7:0]  n_in_y;
    logic [5:0]  n_in_ctrl;
    logic [3:0]  n_in_tag;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [7:0]  n_out_data;
    logic [3:0]  n_out_tag;
    logic        n_out_zr;
    logic        n_out_ng;

    int n_vec;
    int n_err;
    logic [EW-1:0] exp_q[$];

    alu_pipe #(.WIDTH(16), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ctrl   (in_ctrl),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zr    (out_zr),
`ifdef ALU_PIPE_ARITH_FLAGS_EN
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
`endif
        .out_ng    (out_ng)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_x      (n_in_x),
        .in_y      (n_in_y),
        .in_ctrl   (n_in_ctrl),
        .in_tag    (n_in_tag),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .out_tag   (n_out_tag),
        .out_zr    (n_out_zr),
`ifdef ALU_PIPE_ARITH_FLAGS_EN
        .out_carry (n_out_carry),
        .out_ovf   (n_out_ovf),
`endif
        .out_ng    (n_out_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: straight from the function definition, 16-bit operands.
    function automatic logic [EW-1:0] model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c, input logic [3:0] tag);
        logic [15:0] xv;
        logic [15:0] yv;
        logic [15:0] r;
        logic [16:0] s;
        logic        cy;
        logic        ov;
        xv = c[5] ? 16'h0000 : x;
        if (c[4]) xv = ~xv;
        yv = c[3] ? 16'h0000 : y;
        if (c[2]) yv = ~yv;
        s  = {1'b0, xv} + {1'b0, yv};
        r  = c[1] ? s[15:0] : (xv & yv);
        if (c[0]) r = ~r;
        cy = c[1] && s[16];
        ov = c[1] && (xv[15] == yv[15]) && (s[15] != xv[15]);
        return {cy, ov, tag, r};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0 ||
            out_tag !== 4'h0 || out_zr !== 1'b0 || out_ng !== 1'b0) begin
            n_err++;
            $display("FAIL reset: valid=%b ready=%b data=%h tag=%h zr=%b ng=%b, want 0 1 0000 0 0 0",
                     out_valid, in_ready, out_data, out_tag, out_zr, out_ng);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_x = 16'h0005; in_y = 16'h0003; in_ctrl = ALU_ADD; in_tag = 4'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_latency_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h0008 || out_zr !== 1'b0 ||
            out_ng !== 1'b0 || out_tag !== 4'h3) begin
            n_err++;
            $display("FAIL add: valid=%b data=%h zr=%b ng=%b tag=%h, want 1 0008 0 0 3",
                     out_valid, out_data, out_zr, out_ng, out_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_or();
        out_ready = 1'b1;
        in_x = 16'h0003; in_y = 16'h0005; in_ctrl = ALU_SUB; in_tag = 4'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = 16'h00F0; in_y = 16'h000F; in_ctrl = ALU_OR; in_tag = 4'h6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFE || out_ng !== 1'b1 ||
            out_zr !== 1'b0 || out_tag !== 4'h5) begin
            n_err++;
            $display("FAIL sub: valid=%b data=%h zr=%b ng=%b tag=%h, want 1 fffe 0 1 5",
                     out_valid, out_data, out_zr, out_ng, out_tag);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h00FF || out_ng !== 1'b0 ||
            out_zr !== 1'b0 || out_tag !== 4'h6) begin
            n_err++;
            $display("FAIL or: valid=%b data=%h zr=%b ng=%b tag=%h, want 1 00ff 0 0 6",
                     out_valid, out_data, out_zr, out_ng, out_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e;
        int            next_tag;
        int            accepts;
        logic          stall_prev;
        logic [15:0]   prev_data;
        logic [3:0]    prev_tag;
        next_tag   = 1;
        accepts    = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_tag   = '0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 4);
            if (next_tag <= 5) begin
                in_valid = 1'b1;
                in_x     = 16'($urandom);
                in_y     = 16'($urandom);
                in_ctrl  = ALU_ADD;
                in_tag   = 4'(next_tag);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) begin
                n_vec++;
                if (in_ready !== 1'b0 || accepts != 2) begin
                    n_err++;
                    $display("FAIL bp_full: in_ready=%b accepts=%0d, want 0 and 2", in_ready, accepts);
                end
            end
            if (stall_prev) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
                    n_err++;
                    $display("FAIL bp_stable: valid=%b data=%h tag=%h, want 1 %h %h",
                             out_valid, out_data, out_tag, prev_data, prev_tag);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_x, in_y, in_ctrl, in_tag));
                accepts++;
                next_tag++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: tag=%h data=%h, want no output", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tag !== e[19:16] || out_data !== e[15:0] || out_zr !== (e[15:0] == 16'h0) ||
                        out_ng !== e[15]) begin
                        n_err++;
                        $display("FAIL bp_order: tag=%h data=%h, want tag=%h data=%h",
                                 out_tag, out_data, e[19:16], e[15:0]);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: %0d results left, want 0", exp_q.size());
        end
        exp_q.delete();
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in_x = 16'(c); in_y = 16'h0100; in_ctrl = ALU_ADD; in_tag = 4'(c);
            @(negedge clk);
            if (c < 8) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready: cycle %0d in_ready=%b want 1", c, in_ready);
                end
            end
            if (c >= 2) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_tag !== 4'(c - 2) || out_data !== 16'(16'h0100 + c - 2)) begin
                    n_err++;
                    $display("FAIL b2b_out: cycle %0d valid=%b tag=%h data=%h, want 1 %h %h",
                             c, out_valid, out_tag, out_data, 4'(c - 2), 16'(16'h0100 + c - 2));
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        in_ctrl = ALU_X; in_y = 16'h0;
        in_x = 16'h1111; in_tag = 4'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = 16'h2222; in_tag = 4'h8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_zr !== 1'b0 || out_ng !== 1'b0 ||
            out_tag !== 4'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async: valid=%b data=%h zr=%b ng=%b tag=%h ready=%b, want 0 0000 0 0 0 1",
                     out_valid, out_data, out_zr, out_ng, out_tag, in_ready);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_x = 16'h0AAA; in_ctrl = ALU_X; in_tag = 4'hA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
                n_vec++;
                if (out_tag !== 4'hA || out_data !== 16'h0AAA) begin
                    n_err++;
                    $display("FAIL rst_stale: tag=%h data=%h, want a 0aaa", out_tag, out_data);
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen != 1) begin
            n_err++;
            $display("FAIL rst_count: %0d outputs after reset, want 1", seen);
        end
    endtask

    task automatic test_narrow();
        n_out_ready = 1'b1;
        n_in_x = 8'hAB; n_in_y = 8'h00; n_in_ctrl = ALU_ZERO; n_in_tag = 4'h1; n_in_valid = 1'b1;
        @(posedge clk); #1;
        n_in_ctrl = ALU_NEG1; n_in_tag = 4'h2;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (n_out_valid !== 1'b1 || n_out_data !== 8'h00 || n_out_zr !== 1'b1 ||
            n_out_ng !== 1'b0 || n_out_tag !== 4'h1) begin
            n_err++;
            $display("FAIL narrow_zero: valid=%b data=%h zr=%b ng=%b tag=%h, want 1 00 1 0 1",
                     n_out_valid, n_out_data, n_out_zr, n_out_ng, n_out_tag);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (n_out_valid !== 1'b1 || n_out_data !== 8'hFF || n_out_zr !== 1'b0 ||
            n_out_ng !== 1'b1 || n_out_tag !== 4'h2) begin
            n_err++;
            $display("FAIL narrow_neg1: valid=%b data=%h zr=%b ng=%b tag=%h, want 1 ff 0 1 2",
                     n_out_valid, n_out_data, n_out_zr, n_out_ng, n_out_tag);
        end
        @(posedge clk); #1;
    endtask

`ifdef ALU_PIPE_ARITH_FLAGS_EN
    task automatic test_arith_flags();
        out_ready = 1'b1;
        in_x = 16'h7FFF; in_y = 16'h0001; in_ctrl = ALU_ADD; in_tag = 4'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = 16'hFFFF; in_y = 16'h0001; in_ctrl = ALU_ADD; in_tag = 4'h2;
        @(posedge clk); #1;
        in_ctrl = ALU_AND; in_tag = 4'h3;
        @(negedge clk);
        n_vec++;
        if (out_data !== 16'h8000 || out_ovf !== 1'b1 || out_carry !== 1'b0 || out_ng !== 1'b1) begin
            n_err++;
            $display("FAIL flags_ovf: data=%h ovf=%b carry=%b ng=%b, want 8000 1 0 1",
                     out_data, out_ovf, out_carry, out_ng);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_data !== 16'h0000 || out_carry !== 1'b1 || out_zr !== 1'b1 || out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL flags_carry: data=%h carry=%b zr=%b ovf=%b, want 0000 1 1 0",
                     out_data, out_carry, out_zr, out_ovf);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (out_data !== 16'h0001 || out_carry !== 1'b0 || out_ovf !== 1'b0 || out_tag !== 4'h3) begin
            n_err++;
            $display("FAIL flags_and: data=%h carry=%b ovf=%b tag=%h, want 0001 0 0 3",
                     out_data, out_carry, out_ovf, out_tag);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random();
        logic [EW-1:0] e;
        logic          stall_prev;
        logic [15:0]   prev_data;
        logic [3:0]    prev_tag;
        logic          mis;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_tag   = '0;
        for (int c = 0; c < 400; c++) begin
            if (c < 300) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_x     = 16'($urandom);
                in_y     = 16'($urandom);
                in_ctrl  = 6'($urandom_range(0, 63));
                in_tag   = 4'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (stall_prev) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
                    n_err++;
                    $display("FAIL rnd_stable: valid=%b data=%h tag=%h, want 1 %h %h",
                             out_valid, out_data, out_tag, prev_data, prev_tag);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_x, in_y, in_ctrl, in_tag));
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_extra: tag=%h data=%h, want no output", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    mis = (out_tag !== e[19:16]) || (out_data !== e[15:0]) ||
                          (out_zr !== (e[15:0] == 16'h0)) || (out_ng !== e[15]);
`ifdef ALU_PIPE_ARITH_FLAGS_EN
                    mis = mis || (out_carry !== e[21]) || (out_ovf !== e[20]);
`endif
                    if (mis) begin
                        n_err++;
                        $display("FAIL rnd_result: tag=%h data=%h zr=%b ng=%b, want tag=%h data=%h flags(c,o)=%b%b",
                                 out_tag, out_data, out_zr, out_ng, e[19:16], e[15:0], e[21], e[20]);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_drain: %0d results left, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_ctrl = '0; in_tag = '0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_x = '0; n_in_y = '0; n_in_ctrl = '0; n_in_tag = '0; n_out_ready = 1'b1;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_sub_or();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_narrow();
`ifdef ALU_PIPE_ARITH_FLAGS_EN
        test_arith_flags();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
